// File: rtl/bus_err_responder.sv
// rtl/bus_err_responder.sv - default/error subordinate returning windowed error codes on response bursts
module bus_err_responder #(
    parameter int AddrWidth      = 48,
    parameter int MetaDataWidth  = 1,
    parameter int ErrBits        = 3,
    parameter int LenWidth       = 8,
    parameter int NumOutstanding = 4,
    parameter int NumWindows     = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic [AddrWidth-1:0]            req_addr_i,
    input  logic [MetaDataWidth-1:0]        req_meta_i,
    input  logic [LenWidth-1:0]             req_len_i,
    output logic                            rsp_valid_o,
    input  logic                            rsp_ready_i,
    output logic                            rsp_last_o,
    output logic [ErrBits-1:0]              rsp_err_o,
    output logic [MetaDataWidth-1:0]        rsp_meta_o,
    input  logic [NumWindows-1:0]           win_en_i,
    input  logic [NumWindows*AddrWidth-1:0] win_base_i,
    input  logic [NumWindows*AddrWidth-1:0] win_limit_i,
    input  logic [NumWindows*ErrBits-1:0]   win_err_i,
    input  logic [ErrBits-1:0]              default_err_i,
    output logic [31:0]                     err_count_o,
    input  logic                            err_count_clr_i,
    output logic                            busy_o
);

    localparam int PtrW = $clog2(NumOutstanding);
    localparam int CntW = $clog2(NumOutstanding + 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(NumOutstanding);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(NumOutstanding - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    state_e                   r_state;
    state_e                   w_state_nxt;
    logic [PtrW-1:0]          r_wptr;
    logic [PtrW-1:0]          r_rptr;
    logic [CntW-1:0]          r_count;
    logic [CntW-1:0]          w_count_nxt;
    logic                     r_ready;
    logic [LenWidth-1:0]      r_beat_cnt;
    logic [31:0]              r_err_count;

    logic [MetaDataWidth-1:0] r_q_meta [NumOutstanding];
    logic [LenWidth-1:0]      r_q_len  [NumOutstanding];
    logic [ErrBits-1:0]       r_q_code [NumOutstanding];

    logic                     w_hit;
    logic [ErrBits-1:0]       w_code;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_beat_hs;
    logic                     w_last;
    logic                     w_burst;

    // Lowest-index enabled window containing the address wins; base > limit can never contain it.
    always_comb begin
        w_hit  = 1'b0;
        w_code = default_err_i;
        for (int w = 0; w < NumWindows; w++) begin
            if (!w_hit && win_en_i[w] &&
                (win_base_i[w*AddrWidth +: AddrWidth] <= req_addr_i) &&
                (req_addr_i <= win_limit_i[w*AddrWidth +: AddrWidth])) begin
                w_hit  = 1'b1;
                w_code = win_err_i[w*ErrBits +: ErrBits];
            end
        end
    end

    assign w_burst   = (r_state == ST_BURST);
    assign w_push    = req_valid_i && r_ready;
    assign w_beat_hs = w_burst && rsp_ready_i;
    assign w_last    = (r_beat_cnt == r_q_len[r_rptr]);
    assign w_pop     = w_beat_hs && w_last;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CntW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CntW'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_count != '0) begin
                    w_state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                if (w_pop && (w_count_nxt == '0)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_ready    <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            // Ready is a flop of next-cycle "not full" so it never depends on rsp_ready_i.
            r_ready <= (w_count_nxt != FullCnt);
            if (w_push) begin
                r_wptr <= (r_wptr == LastPtr) ? '0 : r_wptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == LastPtr) ? '0 : r_rptr + PtrW'(1);
            end
            if (w_beat_hs) begin
                r_beat_cnt <= w_last ? '0 : r_beat_cnt + LenWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err_count <= '0;
        end else if (err_count_clr_i) begin
            r_err_count <= '0;
        end else if (w_pop && (r_q_code[r_rptr] != '0) && (r_err_count != 32'hFFFF_FFFF)) begin
            r_err_count <= r_err_count + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_q_meta[r_wptr] <= req_meta_i;
            r_q_len[r_wptr]  <= req_len_i;
            r_q_code[r_wptr] <= w_code;
        end
    end

    assign req_ready_o = r_ready;
    assign rsp_valid_o = w_burst;
    assign rsp_last_o  = w_burst && w_last;
    assign rsp_err_o   = w_burst ? r_q_code[r_rptr] : '0;
    assign rsp_meta_o  = w_burst ? r_q_meta[r_rptr] : '0;
    assign err_count_o = r_err_count;
    assign busy_o      = (r_count != '0);

endmodule

// File: tb/tb_bus_err_responder.sv
// tb/tb_bus_err_responder.sv - randomized scoreboard bench for bus_err_responder
module tb_bus_err_responder;

    localparam int AW = 48;
    localparam int MW = 1;
    localparam int EB = 3;
    localparam int LW = 8;
    localparam int NO = 4;
    localparam int NW = 2;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [AW-1:0]     req_addr_i;
    logic [MW-1:0]     req_meta_i;
    logic [LW-1:0]     req_len_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic              rsp_last_o;
    logic [EB-1:0]     rsp_err_o;
    logic [MW-1:0]     rsp_meta_o;
    logic [NW-1:0]     win_en_i;
    logic [NW*AW-1:0]  win_base_i;
    logic [NW*AW-1:0]  win_limit_i;
    logic [NW*EB-1:0]  win_err_i;
    logic [EB-1:0]     default_err_i;
    logic [31:0]       err_count_o;
    logic              err_count_clr_i;
    logic              busy_o;

    logic [AW-1:0]     cfg_base  [NW];
    logic [AW-1:0]     cfg_limit [NW];
    logic [EB-1:0]     cfg_err   [NW];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NW; g++) begin : g_cfg
        assign win_base_i[g*AW +: AW]  = cfg_base[g];
        assign win_limit_i[g*AW +: AW] = cfg_limit[g];
        assign win_err_i[g*EB +: EB]   = cfg_err[g];
    end

    bus_err_responder dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_addr_i      (req_addr_i),
        .req_meta_i      (req_meta_i),
        .req_len_i       (req_len_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .rsp_last_o      (rsp_last_o),
        .rsp_err_o       (rsp_err_o),
        .rsp_meta_o      (rsp_meta_o),
        .win_en_i        (win_en_i),
        .win_base_i      (win_base_i),
        .win_limit_i     (win_limit_i),
        .win_err_i       (win_err_i),
        .default_err_i   (default_err_i),
        .err_count_o     (err_count_o),
        .err_count_clr_i (err_count_clr_i),
        .busy_o          (busy_o)
    );

    typedef struct {
        logic [MW-1:0] meta;
        logic [LW-1:0] len;
        logic [EB-1:0] code;
    } entry_t;

    entry_t        exp_q[$];
    int            beat;
    logic [31:0]   exp_cnt;
    int            occ_prev;
    bit            prev_stall;
    logic          prev_last;
    logic [EB-1:0] prev_err;
    logic [MW-1:0] prev_meta;
    int            n_checks;
    int            n_fail;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [EB-1:0] resolve(input logic [AW-1:0] a);
        for (int w = 0; w < NW; w++) begin
            if (win_en_i[w] && cfg_base[w] <= a && a <= cfg_limit[w]) return cfg_err[w];
        end
        return default_err_i;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        beat       = 0;
        exp_cnt    = '0;
        occ_prev   = 0;
        prev_stall = 1'b0;
    endtask

    // One clock cycle: called at a negedge with inputs already set, checks outputs, advances the model.
    task automatic step();
        int     occ;
        bit     acc;
        bit     hs;
        bit     lst;
        entry_t e;
        occ = exp_q.size();
        check("req_ready", req_ready_o, 64'(occ < NO));
        check("busy", busy_o, 64'(occ != 0));
        check("err_count", err_count_o, exp_cnt);
        check("rsp_valid", rsp_valid_o, 64'(occ_prev > 0 && occ > 0));
        if (prev_stall) begin
            check("stable_last", rsp_last_o, prev_last);
            check("stable_err", rsp_err_o, prev_err);
            check("stable_meta", rsp_meta_o, prev_meta);
        end
        lst = 1'b0;
        if (rsp_valid_o && occ > 0) begin
            e   = exp_q[0];
            lst = (beat == int'(e.len));
            check("rsp_meta", rsp_meta_o, e.meta);
            check("rsp_err", rsp_err_o, e.code);
            check("rsp_last", rsp_last_o, 64'(lst));
        end
        acc = req_valid_i && req_ready_o;
        hs  = rsp_valid_o && rsp_ready_i;
        if (hs && occ > 0) begin
            if (lst) begin
                if (e.code != 0 && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
                void'(exp_q.pop_front());
                beat = 0;
            end else begin
                beat++;
            end
        end
        if (err_count_clr_i) exp_cnt = '0;
        if (acc) begin
            e.meta = req_meta_i;
            e.len  = req_len_i;
            e.code = resolve(req_addr_i);
            exp_q.push_back(e);
        end
        occ_prev   = occ;
        prev_stall = rsp_valid_o && !rsp_ready_i;
        prev_last  = rsp_last_o;
        prev_err   = rsp_err_o;
        prev_meta  = rsp_meta_o;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_single(input logic [AW-1:0] a, input logic [LW-1:0] len, input logic [MW-1:0] m,
                              input bit toggle, output logic [EB-1:0] err_seen, output int beats,
                              output int lat);
        bit phase;
        bit done;
        int cyc;
        err_seen = '0;
        beats    = 0;
        lat      = -1;
        phase    = 1'b1;
        done     = 1'b0;
        check("single_accept", req_ready_o, 1);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        req_len_i   = len;
        req_meta_i  = m;
        rsp_ready_i = 1'b0;
        step();
        req_valid_i = 1'b0;
        cyc = 1;
        while (!done && cyc < 200) begin
            if (rsp_valid_o) begin
                if (lat < 0) begin
                    lat      = cyc;
                    err_seen = rsp_err_o;
                end
                rsp_ready_i = toggle ? phase : 1'b1;
                phase = !phase;
                if (rsp_ready_i) beats++;
                if (rsp_ready_i && rsp_last_o) done = 1'b1;
            end else begin
                rsp_ready_i = 1'b0;
            end
            step();
            cyc++;
        end
        rsp_ready_i = 1'b0;
        check("burst_done", done, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [EB-1:0] err;
        int            beats;
        int            lat;
        int            n_acc;
        int            cyc;

        rst_i = 1'b0;
        req_valid_i = 1'b0; req_addr_i = '0; req_meta_i = '0; req_len_i = '0;
        rsp_ready_i = 1'b0; err_count_clr_i = 1'b0; default_err_i = '0; win_en_i = '0;
        for (int w = 0; w < NW; w++) begin
            cfg_base[w] = '0; cfg_limit[w] = '0; cfg_err[w] = '0;
        end
        n_checks = 0;
        n_fail   = 0;
        model_reset();

        #2 rst_i = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready_o, 0);
        check("rst_valid", rsp_valid_o, 0);
        check("rst_last", rsp_last_o, 0);
        check("rst_err", rsp_err_o, 0);
        check("rst_meta", rsp_meta_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_count", err_count_o, 0);
        rst_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_release_ready", req_ready_o, 1);

        // Single beat, no window match
        run_single(48'h40, 8'd0, 1'b1, 1'b0, err, beats, lat);
        check("t1_latency", lat, 2);
        check("t1_err", err, 0);
        check("t1_beats", beats, 1);
        step();
        check("t1_busy", busy_o, 0);
        check("t1_count", err_count_o, 0);

        // Window hit, 4-beat burst with alternating ready
        cfg_base[0] = 48'h1000; cfg_limit[0] = 48'h1FFF; cfg_err[0] = 3'd3; win_en_i = 2'b01;
        run_single(48'h1800, 8'd3, 1'b0, 1'b1, err, beats, lat);
        check("t2_err", err, 3);
        check("t2_beats", beats, 4);
        check("t2_count", err_count_o, 1);

        // Full queue
        win_en_i = '0;
        rsp_ready_i = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            req_valid_i = 1'b1;
            req_meta_i  = MW'(i);
            req_len_i   = LW'(i);
            req_addr_i  = AW'(i * 16);
            if (req_ready_o) n_acc++;
            step();
        end
        req_valid_i = 1'b0;
        check("t3_accepts", n_acc, 4);
        check("t3_ready_full", req_ready_o, 0);
        rsp_ready_i = 1'b1;
        cyc = 0;
        while (busy_o && cyc < 100) begin
            step();
            cyc++;
        end
        check("t3_drained", busy_o, 0);
        rsp_ready_i = 1'b0;

        // Overlapping windows and boundaries
        default_err_i = 3'd7;
        cfg_base[0] = 48'h0;  cfg_limit[0] = 48'hFF;  cfg_err[0] = 3'd2;
        cfg_base[1] = 48'h80; cfg_limit[1] = 48'h17F; cfg_err[1] = 3'd5;
        win_en_i = 2'b11;
        run_single(48'h90, 8'd0, 1'b0, 1'b0, err, beats, lat);
        check("t4_overlap_low", err, 2);
        run_single(48'h120, 8'd1, 1'b1, 1'b0, err, beats, lat);
        check("t4_win1", err, 5);
        run_single(48'h17F, 8'd0, 1'b0, 1'b0, err, beats, lat);
        check("t4_limit_incl", err, 5);
        run_single(48'h180, 8'd0, 1'b1, 1'b0, err, beats, lat);
        check("t4_past_limit", err, 7);
        win_en_i = 2'b10;
        run_single(48'h90, 8'd0, 1'b0, 1'b0, err, beats, lat);
        check("t4_win0_off", err, 5);
        cfg_base[0] = 48'h200; cfg_limit[0] = 48'h100; win_en_i = 2'b01;
        run_single(48'h180, 8'd0, 1'b0, 1'b0, err, beats, lat);
        check("t4_inverted", err, 7);
        run_single(48'h100, 8'd0, 1'b0, 1'b0, err, beats, lat);
        check("t4_inverted_edge", err, 7);

        // Counter saturation and clear priority
        win_en_i = '0;
        default_err_i = 3'd1;
        force dut.r_err_count = 32'hFFFF_FFFE;
        #1;
        release dut.r_err_count;
        exp_cnt = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            run_single(48'h0, 8'd0, 1'b0, 1'b0, err, beats, lat);
        end
        check("t5_saturated", err_count_o, 32'hFFFF_FFFF);
        req_valid_i = 1'b1; req_len_i = 8'd0;
        step();
        req_valid_i = 1'b0;
        cyc = 0;
        while (!rsp_valid_o && cyc < 10) begin
            step();
            cyc++;
        end
        check("t5_clr_valid", rsp_valid_o, 1);
        rsp_ready_i = 1'b1;
        err_count_clr_i = 1'b1;
        step();
        err_count_clr_i = 1'b0;
        rsp_ready_i = 1'b0;
        check("t5_clr_prio", err_count_o, 0);

        // Reset in the middle of an 8-beat burst
        default_err_i = 3'd4;
        req_valid_i = 1'b1; req_len_i = 8'd7; req_meta_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        cyc = 0;
        while (!rsp_valid_o && cyc < 10) begin
            step();
            cyc++;
        end
        rsp_ready_i = 1'b1;
        repeat (3) step();
        #2 rst_i = 1'b1;
        #1;
        check("t6_valid_in_rst", rsp_valid_o, 0);
        check("t6_busy_in_rst", busy_o, 0);
        check("t6_ready_in_rst", req_ready_o, 0);
        model_reset();
        rsp_ready_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t6_ready_held", req_ready_o, 0);
        rst_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rsp_ready_i = 1'b1;
        repeat (4) step();
        rsp_ready_i = 1'b0;
        run_single(48'h10, 8'd0, 1'b0, 1'b0, err, beats, lat);
        check("t6_new_latency", lat, 2);
        check("t6_new_err", err, 4);

        // Randomized traffic with reconfiguration on the fly
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                for (int w = 0; w < NW; w++) begin
                    cfg_base[w]  = AW'($urandom_range(0, 'h3FF));
                    cfg_limit[w] = AW'($urandom_range(0, 'h3FF));
                    cfg_err[w]   = EB'($urandom_range(0, 7));
                end
                win_en_i      = NW'($urandom_range(0, 3));
                default_err_i = EB'($urandom_range(0, 7));
            end
            req_valid_i     = 1'($urandom_range(0, 1));
            req_addr_i      = AW'($urandom_range(0, 'h3FF));
            req_len_i       = LW'($urandom_range(0, 3));
            req_meta_i      = MW'($urandom_range(0, 1));
            rsp_ready_i     = ($urandom_range(0, 3) != 0);
            err_count_clr_i = ($urandom_range(0, 99) == 0);
            step();
        end
        req_valid_i = 1'b0;
        err_count_clr_i = 1'b0;
        rsp_ready_i = 1'b1;
        cyc = 0;
        while (busy_o && cyc < 200) begin
            step();
            cyc++;
        end
        step();
        check("final_idle", busy_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
